// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and byte-merge helper for sram_port_arbiter
package sram_arb_pkg;
  typedef enum logic [1:0] {IDLE, RSP, RMW_WR} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;
  function automatic logic [63:0] merge_bytes(input logic [63:0] old_w, input logic [63:0] new_w, input logic [7:0] strb);
    for (int i = 0; i < 8; i++) merge_bytes[i*8+:8] = strb[i] ? new_w[i*8+:8] : old_w[i*8+:8];
  endfunction
endpackage

// File: rtl/sram_arb_grant2.sv
// sram_arb_grant2: 2-way grant, data-over-fetch or round-robin when SRAM_ARB_ROUND_ROBIN_EN is defined
module sram_arb_grant2 import sram_arb_pkg::*; (
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  input  logic clk,
  input  logic rst,
`endif
  input  logic en,
  input  logic req_if,
  input  logic req_d,
  output logic gnt_if,
  output logic gnt_d
);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  owner_t last_grant_q, last_grant_d;
  // on contention favour the port that did not win last time
  always_comb begin
    gnt_d = en & req_d & (~req_if | last_grant_q == OWN_IF);
    gnt_if = en & req_if & ~gnt_d;
    last_grant_d = gnt_d ? OWN_D : gnt_if ? OWN_IF : last_grant_q;
  end
  // remember the most recent grant
  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= OWN_IF;
    else last_grant_q <= last_grant_d;
  end
`else
  // data port always wins
  always_comb begin
    gnt_d = en & req_d;
    gnt_if = en & req_if & ~req_d;
  end
`endif
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one word SRAM between fetch and load/store ports (SRAM_ARB_ROUND_ROBIN_EN selects round-robin)
module sram_port_arbiter import sram_arb_pkg::*; #(
  parameter int XLEN = 32,
  parameter int DEPTH = 262144
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [XLEN-1:0]   if_req_addr,
  output logic              if_rsp_valid,
  output logic [XLEN-1:0]   if_rsp_data,
  output logic              if_rsp_err,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_we,
  input  logic [XLEN-1:0]   d_req_addr,
  input  logic [XLEN-1:0]   d_req_wdata,
  input  logic [XLEN/8-1:0] d_req_wstrb,
  output logic              d_rsp_valid,
  output logic [XLEN-1:0]   d_rsp_rdata,
  output logic              d_rsp_err,
  output logic              sram_we,
  output logic [$clog2(DEPTH)-1:0] sram_addr,
  output logic [XLEN-1:0]   sram_wdata,
  input  logic [XLEN-1:0]   sram_rdata
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = XLEN / 8;
  state_t state_q, state_d;
  owner_t own_q, own_d;
  logic rd_q, rd_d, err_q, err_d;
  logic [AW-1:0] wa_q, wa_d;
  logic [XLEN-1:0] wd_q, wd_d;
  logic [SW-1:0] ws_q, ws_d;
  logic en, gnt_if, gnt_d, acc, oor, st, full, part, rsp, unused_addr_lsbs;
  logic [XLEN-3:0] addr;
  assign unused_addr_lsbs = ^{if_req_addr[1:0], d_req_addr[1:0]};
  assign en = ~rst & (state_q != RMW_WR);
  sram_arb_grant2 u_grant (
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    .clk(clk),
    .rst(rst),
`endif
    .en(en),
    .req_if(if_req_valid),
    .req_d(d_req_valid),
    .gnt_if(gnt_if),
    .gnt_d(gnt_d)
  );
  // request decode and SRAM drive; the RMW cycle replays the registered store
  always_comb begin
    acc = gnt_if | gnt_d;
    addr = gnt_d ? d_req_addr[XLEN-1:2] : if_req_addr[XLEN-1:2];
    oor = |addr[XLEN-3:AW];
    st = gnt_d & d_req_we;
    full = &d_req_wstrb;
    part = ~full & |d_req_wstrb;
    if_req_ready = en & (gnt_if | ~if_req_valid);
    d_req_ready = en & (gnt_d | ~d_req_valid);
    sram_we = state_q == RMW_WR ? ~rst : st & full & ~oor;
    sram_addr = state_q == RMW_WR ? wa_q : addr[AW-1:0];
    sram_wdata = state_q == RMW_WR ? XLEN'(merge_bytes(64'(sram_rdata), 64'(wd_q), 8'(ws_q))) : d_req_wdata;
  end
  // next state and response bookkeeping
  always_comb begin
    state_d = IDLE;
    own_d = own_q;
    rd_d = 1'b0;
    err_d = 1'b0;
    wa_d = wa_q;
    wd_d = wd_q;
    ws_d = ws_q;
    if (state_q == RMW_WR) begin
      state_d = RSP;
      own_d = OWN_D;
    end else if (acc) begin
      state_d = st & part & ~oor ? RMW_WR : RSP;
      own_d = gnt_d ? OWN_D : OWN_IF;
      rd_d = ~st & ~oor;
      err_d = oor;
      wa_d = addr[AW-1:0];
      wd_d = d_req_wdata;
      ws_d = d_req_wstrb;
    end
  end
  // state and registered request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      own_q <= OWN_IF;
      rd_q <= 1'b0;
      err_q <= 1'b0;
      wa_q <= '0;
      wd_q <= '0;
      ws_q <= '0;
    end else begin
      state_q <= state_d;
      own_q <= own_d;
      rd_q <= rd_d;
      err_q <= err_d;
      wa_q <= wa_d;
      wd_q <= wd_d;
      ws_q <= ws_d;
    end
  end
  // route the due response to its owner; read data comes straight from the SRAM output register
  always_comb begin
    rsp = ~rst & (state_q == RSP);
    if_rsp_valid = rsp & (own_q == OWN_IF);
    d_rsp_valid = rsp & (own_q == OWN_D);
    if_rsp_data = if_rsp_valid & rd_q ? sram_rdata : '0;
    d_rsp_rdata = d_rsp_valid & rd_q ? sram_rdata : '0;
    if_rsp_err = if_rsp_valid & err_q;
    d_rsp_err = d_rsp_valid & err_q;
  end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: random and directed checks of sram_port_arbiter against a transaction-level model
module tb_sram_port_arbiter;
  localparam int XLEN = 32;
  localparam int DEPTH = 262144;
  localparam int AW = $clog2(DEPTH);
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic if_req_valid = 1'b0, if_req_ready, if_rsp_valid, if_rsp_err;
  logic [31:0] if_req_addr = '0, if_rsp_data;
  logic d_req_valid = 1'b0, d_req_ready, d_req_we = 1'b0, d_rsp_valid, d_rsp_err;
  logic [31:0] d_req_addr = '0, d_req_wdata = '0, d_rsp_rdata;
  logic [3:0] d_req_wstrb = '0;
  logic sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;
  logic [31:0] sram_mem [DEPTH];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata), .d_rsp_err(d_rsp_err),
    .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always @(posedge clk) begin
    if (sram_we) sram_mem[sram_addr] <= sram_wdata;
    else sram_rdata <= sram_mem[sram_addr];
  end

  typedef struct {bit ifv; bit dv; logic [31:0] data; bit err;} rsp_t;
  rsp_t p0, p1, none;
  logic [31:0] ref_mem [int];
  bit busy = 0, wr_pend = 0, last_d = 0;
  int wr_idx;
  logic [31:0] wr_val;

  function automatic logic [31:0] rd(int i);
    return ref_mem.exists(i) ? ref_mem[i] : 32'h0;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_if(bit v, logic [31:0] a);
    if_req_valid = v;
    if_req_addr = a;
  endtask

  task automatic set_d(bit v, bit we, logic [31:0] a, logic [31:0] wd, logic [3:0] s);
    d_req_valid = v;
    d_req_we = we;
    d_req_addr = a;
    d_req_wdata = wd;
    d_req_wstrb = s;
  endtask

  task automatic cycle();
    bit gi, gd, en, full, oor, ev;
    int idx;
    logic [31:0] a, v;
    @(negedge clk);
    en = !rst && !busy;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    gd = en && d_req_valid && (!if_req_valid || !last_d);
`else
    gd = en && d_req_valid;
`endif
    gi = en && if_req_valid && !gd;
    a = gd ? d_req_addr : if_req_addr;
    oor = a >= 32'(4 * DEPTH);
    idx = int'(a / 4);
    full = d_req_wstrb == 4'hF;
    chk("if_ready", 32'(if_req_ready), 32'(en && (gi || !if_req_valid)));
    chk("d_ready", 32'(d_req_ready), 32'(en && (gd || !d_req_valid)));
    chk("sram_we", 32'(sram_we), 32'(!rst && (busy || (gd && d_req_we && full && !oor))));
    ev = !rst && p0.ifv;
    chk("if_rsp_valid", 32'(if_rsp_valid), 32'(ev));
    chk("if_rsp_data", if_rsp_data, ev ? p0.data : 32'h0);
    chk("if_rsp_err", 32'(if_rsp_err), 32'(ev && p0.err));
    ev = !rst && p0.dv;
    chk("d_rsp_valid", 32'(d_rsp_valid), 32'(ev));
    chk("d_rsp_rdata", d_rsp_rdata, ev ? p0.data : 32'h0);
    chk("d_rsp_err", 32'(d_rsp_err), 32'(ev && p0.err));
    if (!rst && wr_pend) ref_mem[wr_idx] = wr_val;
    wr_pend = 0;
    busy = 0;
    p0 = p1;
    p1 = none;
    if (rst) begin
      p0 = none;
      last_d = 0;
    end else if (gi || gd) begin
      last_d = gd;
      p0 = '{ifv: gi, dv: gd, data: 32'h0, err: oor};
      if (!oor) begin
        if (gi || !d_req_we) p0.data = rd(idx);
        else if (full) ref_mem[idx] = d_req_wdata;
        else if (d_req_wstrb != 4'h0) begin
          v = rd(idx);
          for (int b = 0; b < 4; b++) if (d_req_wstrb[b]) v[b*8+:8] = d_req_wdata[b*8+:8];
          wr_pend = 1;
          wr_idx = idx;
          wr_val = v;
          busy = 1;
          p1 = p0;
          p0 = none;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int r;
    none = '{ifv: 0, dv: 0, data: 32'h0, err: 0};
    p0 = none;
    p1 = none;
    // reset with both ports requesting
    rst = 1;
    set_if(1, 32'h0);
    set_d(1, 1, 32'h0, 32'hA5A5A5A5, 4'hF);
    cycle();
    cycle();
    rst = 0;
    cycle();
    set_d(0, 0, 0, 0, 0);
    cycle();
    set_if(0, 0);
    // preload words 1..15
    for (int i = 1; i < 16; i++) begin
      set_d(1, 1, 32'(i * 4), $urandom, 4'hF);
      cycle();
    end
    // full store then back-to-back load
    set_d(1, 1, 32'h100, 32'hDEADBEEF, 4'hF);
    cycle();
    set_d(1, 0, 32'h100, 32'h0, 4'h0);
    cycle();
    set_d(0, 0, 0, 0, 0);
    cycle();
    // partial store read-modify-write
    set_d(1, 1, 32'h40, 32'h11223344, 4'hF);
    cycle();
    set_d(1, 1, 32'h40, 32'h0000AA00, 4'b0010);
    cycle();
    set_d(1, 0, 32'h40, 32'h0, 4'h0);
    cycle();
    cycle();
    set_d(0, 0, 0, 0, 0);
    cycle();
    // contention for 4 cycles
    set_if(1, 32'h4);
    set_d(1, 0, 32'h8, 32'h0, 4'h0);
    for (int i = 0; i < 4; i++) cycle();
    set_if(0, 0);
    set_d(0, 0, 0, 0, 0);
    cycle();
    // out of range load, store and fetch
    set_d(1, 0, 32'(4 * DEPTH), 32'h0, 4'h0);
    cycle();
    set_d(1, 1, 32'(4 * DEPTH), 32'h12345678, 4'hF);
    cycle();
    set_d(0, 0, 0, 0, 0);
    set_if(1, 32'(4 * DEPTH + 8));
    cycle();
    set_if(0, 0);
    cycle();
    // reset in the RMW write cycle abandons the store
    set_d(1, 1, 32'h14, 32'h00EE0000, 4'b0100);
    cycle();
    rst = 1;
    set_d(0, 0, 0, 0, 0);
    cycle();
    rst = 0;
    set_d(1, 0, 32'h14, 32'h0, 4'h0);
    cycle();
    set_d(0, 0, 0, 0, 0);
    cycle();
    // random traffic
    for (int n = 0; n < 400; n++) begin
      set_if($urandom_range(0, 1) == 1, ($urandom_range(0, 9) == 0) ? ($urandom | 32'h0010_0000) : 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3)));
      r = $urandom_range(0, 3);
      set_d($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            ($urandom_range(0, 9) == 0) ? ($urandom | 32'h0010_0000) : 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3)),
            $urandom, r == 0 ? 4'hF : r == 1 ? 4'h0 : 4'($urandom_range(0, 15)));
      cycle();
    end
    set_if(0, 0);
    set_d(0, 0, 0, 0, 0);
    cycle();
    cycle();
    cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
